// File: rtl/bitbakery_pkg.sv
// rtl/bitbakery_pkg.sv - shared state codes and sizing helpers for the minigame sequencer
package bitbakery_pkg;

   typedef enum logic [2:0] {
      INICIAL    = 3'd0,
      PREPARACAO = 3'd1,
      EXECUCAO   = 3'd2,
      FIM        = 3'd3,
      INTERVALO  = 3'd4,
      START      = 3'd5
   } seq_state_e;

   // Truncated to the select width at the use site; all-ones means "no game".
   localparam logic [31:0] NO_GAME_ALL = '1;

   function automatic int sat_sum_w(input int total_w, input int score_w);
      return ((total_w > score_w) ? total_w : score_w) + 1;
   endfunction

endpackage

// File: rtl/minigame_sequencer_if.sv
// rtl/minigame_sequencer_if.sv - bus between the sequencer and its attached minigames
interface minigame_sequencer_if #(
   parameter int N_GAMES = 3,
   parameter int STATE_W = 4,
   parameter int SCORE_W = 3
);
   logic [N_GAMES-1:0]         jogar;
   logic [N_GAMES*STATE_W-1:0] game_estado;
   logic [N_GAMES-1:0]         game_pronto;
   logic [N_GAMES*SCORE_W-1:0] game_pontuacao;

   modport master (output jogar, input game_estado, game_pronto, game_pontuacao);
   modport slave  (input jogar, output game_estado, game_pronto, game_pontuacao);
endinterface

// File: rtl/minigame_sequencer_seq_timer.sv
// rtl/minigame_sequencer_seq_timer.sv - clear/enable counter with a terminal-count flag
module seq_timer #(
   parameter int TERMINAL = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic terminal
);
   localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
   localparam logic [CW-1:0] TC = CW'((TERMINAL > 0) ? TERMINAL - 1 : 0);

   logic [CW-1:0] count_q, count_d;

   // TERMINAL of 0 disables the flag entirely.
   assign terminal = (TERMINAL > 0) && (count_q == TC);

   always_comb begin
      count_d = count_q;
      if (clear)
         count_d = '0;
      else if (enable && !terminal)
         count_d = count_q + CW'(1);
   end

   always_ff @(posedge clock) begin
      if (reset)
         count_q <= '0;
      else
         count_q <= count_d;
   end
endmodule

// File: rtl/minigame_sequencer.sv
// rtl/minigame_sequencer.sv - N-game select/interval/start/execute/end sequencer with tournament mode
module minigame_sequencer #(
   parameter int N_GAMES         = 3,
   parameter int SEL_W           = 2,
   parameter int STATE_W         = 4,
   parameter int SCORE_W         = 3,
   parameter int TOTAL_W         = 5,
   parameter int INTERVAL_CYCLES = 2000,
   parameter int TIMEOUT_CYCLES  = 0
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               iniciar,
   input  logic               dificuldade,
   input  logic [SEL_W-1:0]   minigame,
   input  logic               modo_torneio,
   minigame_sequencer_if.master games,
   output logic [SEL_W-1:0]   game_sel,
   output logic               dificuldade_out,
   output logic [STATE_W-1:0] estado_out,
   output logic [TOTAL_W-1:0] pontuacao_total,
   output logic [SEL_W-1:0]   rodada,
   output logic               timeout,
   output logic               pronto,
   output logic [2:0]         db_estado_seq
);
   import bitbakery_pkg::*;

   localparam int SUM_W = sat_sum_w(TOTAL_W, SCORE_W);
   localparam logic [SEL_W-1:0]   NO_GAME   = SEL_W'(NO_GAME_ALL);
   localparam logic [SEL_W-1:0]   N_SEL     = SEL_W'(N_GAMES);
   localparam logic [SEL_W-1:0]   LAST_SEL  = SEL_W'(N_GAMES - 1);
   localparam logic [SEL_W-1:0]   ONE_SEL   = SEL_W'(1);
   localparam logic [TOTAL_W-1:0] TOTAL_MAX = '1;

   seq_state_e         state_q, state_d;
   logic [SEL_W-1:0]   game_sel_q, game_sel_d;
   logic               dific_q, dific_d;
   logic [TOTAL_W-1:0] total_q, total_d;
   logic [SEL_W-1:0]   rodada_q, rodada_d;
   logic               timeout_q, timeout_d;
   logic               torneio_q, torneio_d;

   logic               interval_done, exec_expired;
   logic               sel_pronto;
   logic [SCORE_W-1:0] sel_score;
   logic [STATE_W-1:0] sel_estado;
   logic [SEL_W-1:0]   sel_req;
   logic [SUM_W-1:0]   sum;
   logic [TOTAL_W-1:0] sat_total;

   seq_timer #(.TERMINAL(INTERVAL_CYCLES)) u_interval (
      .clock    (clock),
      .reset    (reset),
      .clear    (state_q != INTERVALO),
      .enable   (state_q == INTERVALO),
      .terminal (interval_done)
   );

   seq_timer #(.TERMINAL(TIMEOUT_CYCLES)) u_timeout (
      .clock    (clock),
      .reset    (reset),
      .clear    (state_q != EXECUCAO),
      .enable   (state_q == EXECUCAO),
      .terminal (exec_expired)
   );

   always_comb begin
      sel_pronto = 1'b0;
      sel_score  = '0;
      sel_estado = '0;
      games.jogar = '0;
      for (int k = 0; k < N_GAMES; k++) begin
         if (game_sel_q == SEL_W'(k)) begin
            sel_pronto  = games.game_pronto[k];
            sel_score   = games.game_pontuacao[k*SCORE_W +: SCORE_W];
            sel_estado  = games.game_estado[k*STATE_W +: STATE_W];
            games.jogar[k] = (state_q == START);
         end
      end
   end

   assign sum       = SUM_W'(total_q) + SUM_W'(sel_score);
   assign sat_total = (sum > SUM_W'(TOTAL_MAX)) ? TOTAL_MAX : TOTAL_W'(sum);
   assign sel_req   = modo_torneio ? '0 : minigame;

   always_comb begin
      state_d    = state_q;
      game_sel_d = game_sel_q;
      dific_d    = dific_q;
      total_d    = total_q;
      rodada_d   = rodada_q;
      timeout_d  = timeout_q;
      torneio_d  = torneio_q;
      case (state_q)
         INICIAL, FIM: begin
            if (iniciar) begin
               state_d   = PREPARACAO;
               total_d   = '0;
               rodada_d  = '0;
               timeout_d = 1'b0;
            end
         end
         PREPARACAO: begin
            // Validity is judged on the value being loaded, so a corrected
            // selection leaves on the very next edge.
            dific_d    = dificuldade;
            game_sel_d = sel_req;
            if (sel_req < N_SEL) begin
               state_d   = INTERVALO;
               torneio_d = modo_torneio;
            end
         end
         INTERVALO: if (interval_done) state_d = START;
         START:     state_d = EXECUCAO;
         EXECUCAO: begin
            if (sel_pronto) begin
               total_d  = sat_total;
               rodada_d = rodada_q + ONE_SEL;
               if (torneio_q && (game_sel_q < LAST_SEL)) begin
                  game_sel_d = game_sel_q + ONE_SEL;
                  state_d    = INTERVALO;
               end else begin
                  state_d = FIM;
               end
            end else if (exec_expired) begin
               timeout_d = 1'b1;
               state_d   = FIM;
            end
         end
         default: state_d = INICIAL;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= INICIAL;
         game_sel_q <= NO_GAME;
         dific_q    <= 1'b0;
         total_q    <= '0;
         rodada_q   <= '0;
         timeout_q  <= 1'b0;
         torneio_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         game_sel_q <= game_sel_d;
         dific_q    <= dific_d;
         total_q    <= total_d;
         rodada_q   <= rodada_d;
         timeout_q  <= timeout_d;
         torneio_q  <= torneio_d;
      end
   end

   always_comb begin
      case (state_q)
         INTERVALO:          estado_out = STATE_W'(1);
         START, EXECUCAO, FIM: estado_out = sel_estado;
         default:            estado_out = STATE_W'(state_q);
      endcase
   end

   assign game_sel        = game_sel_q;
   assign dificuldade_out = dific_q;
   assign pontuacao_total = total_q;
   assign rodada          = rodada_q;
   assign timeout         = timeout_q;
   assign pronto          = (state_q == FIM);
   assign db_estado_seq   = state_q;
endmodule

// File: tb/tb_minigame_sequencer.sv
// tb/tb_minigame_sequencer.sv - directed self-checking bench for minigame_sequencer
module tb_minigame_sequencer;
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       iniciar = 1'b0;
   logic       dificuldade = 1'b0;
   logic       modo_torneio = 1'b0;
   logic [1:0] minigame = 2'd0;

   logic [1:0] game_sel, rodada, game_sel_b, rodada_b;
   logic       dif_out, timeout, pronto, dif_out_b, timeout_b, pronto_b;
   logic [3:0] estado_out, estado_out_b;
   logic [4:0] tot;
   logic [3:0] tot_b;
   logic [2:0] db, db_b;

   int n_total = 0;
   int n_bad = 0;

   minigame_sequencer_if #(.N_GAMES(3), .STATE_W(4), .SCORE_W(3)) gbus ();
   minigame_sequencer_if #(.N_GAMES(3), .STATE_W(4), .SCORE_W(3)) gbus_b ();

   assign gbus_b.game_estado    = gbus.game_estado;
   assign gbus_b.game_pronto    = gbus.game_pronto;
   assign gbus_b.game_pontuacao = gbus.game_pontuacao;

   minigame_sequencer #(.N_GAMES(3), .SEL_W(2), .STATE_W(4), .SCORE_W(3), .TOTAL_W(5),
                        .INTERVAL_CYCLES(8), .TIMEOUT_CYCLES(20)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade(dificuldade),
      .minigame(minigame), .modo_torneio(modo_torneio), .games(gbus),
      .game_sel(game_sel), .dificuldade_out(dif_out), .estado_out(estado_out),
      .pontuacao_total(tot), .rodada(rodada), .timeout(timeout), .pronto(pronto),
      .db_estado_seq(db)
   );

   minigame_sequencer #(.N_GAMES(3), .SEL_W(2), .STATE_W(4), .SCORE_W(3), .TOTAL_W(4),
                        .INTERVAL_CYCLES(8), .TIMEOUT_CYCLES(20)) dut_b (
      .clock(clock), .reset(reset), .iniciar(iniciar), .dificuldade(dificuldade),
      .minigame(minigame), .modo_torneio(modo_torneio), .games(gbus_b),
      .game_sel(game_sel_b), .dificuldade_out(dif_out_b), .estado_out(estado_out_b),
      .pontuacao_total(tot_b), .rodada(rodada_b), .timeout(timeout_b), .pronto(pronto_b),
      .db_estado_seq(db_b)
   );

   always #5 clock = ~clock;

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic wait_state(input logic [2:0] code, input int limit, output int n);
      n = 0;
      while (db != code && n < limit) begin
         tick();
         n++;
      end
   endtask

   task automatic count_state(input logic [2:0] code, input int limit, output int n);
      n = 0;
      while (db == code && n < limit) begin
         n++;
         tick();
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      tick();
      tick();
      n_total++; if (db !== 3'd0) begin n_bad++; $display("FAIL rst_state got=%0d exp=0", db); end
      n_total++; if (game_sel !== 2'b11) begin n_bad++; $display("FAIL rst_sel got=%0d exp=3", game_sel); end
      n_total++; if (dif_out !== 1'b0) begin n_bad++; $display("FAIL rst_dif got=%0b exp=0", dif_out); end
      n_total++; if (gbus.jogar !== 3'b000) begin n_bad++; $display("FAIL rst_jogar got=%b exp=000", gbus.jogar); end
      n_total++; if ({tot, rodada, timeout, pronto} !== 9'd0) begin n_bad++; $display("FAIL rst_outs got=%h exp=0", {tot, rodada, timeout, pronto}); end
      n_total++; if (estado_out !== 4'd0) begin n_bad++; $display("FAIL rst_estado got=%0h exp=0", estado_out); end
      reset = 1'b0;
   endtask

   task automatic test_single;
      int n;
      minigame = 2'd1;
      iniciar = 1'b1;
      tick();
      n_total++; if (db !== 3'd1) begin n_bad++; $display("FAIL single_prep got=%0d exp=1", db); end
      iniciar = 1'b0;
      tick();
      n_total++; if (db !== 3'd4) begin n_bad++; $display("FAIL single_intv got=%0d exp=4", db); end
      n_total++; if (estado_out !== 4'b0001) begin n_bad++; $display("FAIL single_intv_estado got=%0h exp=1", estado_out); end
      count_state(3'd4, 50, n);
      n_total++; if (n !== 8) begin n_bad++; $display("FAIL single_intv_len got=%0d exp=8", n); end
      n_total++; if (gbus.jogar !== 3'b010) begin n_bad++; $display("FAIL single_jogar got=%b exp=010", gbus.jogar); end
      tick();
      n_total++; if (db !== 3'd2) begin n_bad++; $display("FAIL single_exec got=%0d exp=2", db); end
      n_total++; if (gbus.jogar !== 3'b000) begin n_bad++; $display("FAIL single_pulse got=%b exp=000", gbus.jogar); end
      n_total++; if (estado_out !== 4'hB) begin n_bad++; $display("FAIL single_estado got=%0h exp=b", estado_out); end
      gbus.game_pronto = 3'b101;
      tick();
      n_total++; if (db !== 3'd2) begin n_bad++; $display("FAIL single_ignore got=%0d exp=2", db); end
      gbus.game_pronto = 3'b010;
      gbus.game_pontuacao[5:3] = 3'd5;
      tick();
      gbus.game_pronto = 3'b000;
      n_total++; if (db !== 3'd3) begin n_bad++; $display("FAIL single_fim got=%0d exp=3", db); end
      n_total++; if (tot !== 5'd5) begin n_bad++; $display("FAIL single_total got=%0d exp=5", tot); end
      n_total++; if (rodada !== 2'd1) begin n_bad++; $display("FAIL single_rodada got=%0d exp=1", rodada); end
      n_total++; if (pronto !== 1'b1) begin n_bad++; $display("FAIL single_pronto got=%0b exp=1", pronto); end
   endtask

   task automatic test_invalid;
      int n;
      minigame = 2'd3;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n_total++; if (tot !== 5'd0 || rodada !== 2'd0) begin n_bad++; $display("FAIL inv_clear got=%0d/%0d exp=0/0", tot, rodada); end
      repeat (10) tick();
      n_total++; if (db !== 3'd1) begin n_bad++; $display("FAIL inv_hold got=%0d exp=1", db); end
      n_total++; if (game_sel !== 2'd3) begin n_bad++; $display("FAIL inv_track got=%0d exp=3", game_sel); end
      minigame = 2'd0;
      tick();
      n_total++; if (db !== 3'd4 || game_sel !== 2'd0) begin n_bad++; $display("FAIL inv_go got=%0d/%0d exp=4/0", db, game_sel); end
      count_state(3'd4, 50, n);
      n_total++; if (gbus.jogar !== 3'b001) begin n_bad++; $display("FAIL inv_jogar got=%b exp=001", gbus.jogar); end
      tick();
      gbus.game_pontuacao = 9'o111;
      gbus.game_pontuacao[2:0] = 3'd2;
      gbus.game_pronto = 3'b001;
      tick();
      gbus.game_pronto = 3'b000;
      n_total++; if (db !== 3'd3 || tot !== 5'd2) begin n_bad++; $display("FAIL inv_score got=%0d/%0d exp=3/2", db, tot); end
   endtask

   task automatic test_tournament;
      int n;
      logic [2:0] sc [3];
      logic [4:0] cum [3];
      sc = '{3'd3, 3'd4, 3'd7};
      cum = '{5'd3, 5'd7, 5'd14};
      modo_torneio = 1'b1;
      minigame = 2'd2;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      n_total++; if (db !== 3'd4 || game_sel !== 2'd0) begin n_bad++; $display("FAIL tour_start got=%0d/%0d exp=4/0", db, game_sel); end
      modo_torneio = 1'b0;
      for (int g = 0; g < 3; g++) begin
         if (g == 1) iniciar = 1'b1;
         count_state(3'd4, 50, n);
         iniciar = 1'b0;
         n_total++; if (n !== 8) begin n_bad++; $display("FAIL tour_intv%0d got=%0d exp=8", g, n); end
         n_total++; if (gbus.jogar !== (3'b001 << g)) begin n_bad++; $display("FAIL tour_jogar%0d got=%b exp=%b", g, gbus.jogar, 3'b001 << g); end
         tick();
         gbus.game_pontuacao = 9'o111;
         gbus.game_pontuacao[g*3 +: 3] = sc[g];
         gbus.game_pronto = 3'b001 << g;
         tick();
         gbus.game_pronto = 3'b000;
         n_total++; if (tot !== cum[g]) begin n_bad++; $display("FAIL tour_total%0d got=%0d exp=%0d", g, tot, cum[g]); end
         n_total++; if (rodada !== 2'(g + 1)) begin n_bad++; $display("FAIL tour_rodada%0d got=%0d exp=%0d", g, rodada, g + 1); end
         n_total++; if (db !== ((g < 2) ? 3'd4 : 3'd3)) begin n_bad++; $display("FAIL tour_next%0d got=%0d", g, db); end
      end
   endtask

   task automatic test_saturation;
      int n;
      logic [4:0] ea [3];
      logic [3:0] eb [3];
      ea = '{5'd7, 5'd14, 5'd21};
      eb = '{4'd7, 4'd14, 4'd15};
      modo_torneio = 1'b1;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      modo_torneio = 1'b0;
      for (int g = 0; g < 3; g++) begin
         count_state(3'd4, 50, n);
         tick();
         gbus.game_pontuacao = 9'o777;
         gbus.game_pronto = 3'b001 << g;
         tick();
         gbus.game_pronto = 3'b000;
         n_total++; if (tot !== ea[g]) begin n_bad++; $display("FAIL sat_wide%0d got=%0d exp=%0d", g, tot, ea[g]); end
         n_total++; if (tot_b !== eb[g]) begin n_bad++; $display("FAIL sat_narrow%0d got=%0d exp=%0d", g, tot_b, eb[g]); end
      end
   endtask

   task automatic test_timeout;
      int n;
      minigame = 2'd2;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      wait_state(3'd5, 50, n);
      tick();
      n_total++; if (db !== 3'd2 || estado_out !== 4'hC) begin n_bad++; $display("FAIL to_exec got=%0d/%0h exp=2/c", db, estado_out); end
      count_state(3'd2, 100, n);
      n_total++; if (n !== 20) begin n_bad++; $display("FAIL to_len got=%0d exp=20", n); end
      n_total++; if (db !== 3'd3 || timeout !== 1'b1) begin n_bad++; $display("FAIL to_fim got=%0d/%0b exp=3/1", db, timeout); end
      n_total++; if (tot !== 5'd0 || rodada !== 2'd0) begin n_bad++; $display("FAIL to_noscore got=%0d/%0d exp=0/0", tot, rodada); end
      modo_torneio = 1'b1;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      n_total++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL to_clear got=%0b exp=0", timeout); end
      wait_state(3'd5, 50, n);
      tick();
      gbus.game_pontuacao = 9'o111;
      gbus.game_pontuacao[2:0] = 3'd4;
      gbus.game_pronto = 3'b001;
      tick();
      gbus.game_pronto = 3'b000;
      wait_state(3'd5, 50, n);
      tick();
      count_state(3'd2, 100, n);
      modo_torneio = 1'b0;
      n_total++; if (n !== 20 || db !== 3'd3) begin n_bad++; $display("FAIL to_tour got=%0d/%0d exp=20/3", n, db); end
      n_total++; if (tot !== 5'd4 || rodada !== 2'd1) begin n_bad++; $display("FAIL to_tour_score got=%0d/%0d exp=4/1", tot, rodada); end
      n_total++; if (game_sel !== 2'd1 || timeout !== 1'b1) begin n_bad++; $display("FAIL to_tour_sel got=%0d/%0b exp=1/1", game_sel, timeout); end
   endtask

   task automatic test_late_done;
      int n;
      minigame = 2'd0;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      wait_state(3'd5, 50, n);
      tick();
      repeat (19) tick();
      n_total++; if (db !== 3'd2) begin n_bad++; $display("FAIL late_exec got=%0d exp=2", db); end
      gbus.game_pontuacao = 9'o111;
      gbus.game_pontuacao[2:0] = 3'd6;
      gbus.game_pronto = 3'b001;
      tick();
      gbus.game_pronto = 3'b000;
      n_total++; if (db !== 3'd3 || tot !== 5'd6) begin n_bad++; $display("FAIL late_score got=%0d/%0d exp=3/6", db, tot); end
      n_total++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL late_timeout got=%0b exp=0", timeout); end
   endtask

   task automatic test_freeze_reset;
      int n;
      modo_torneio = 1'b1;
      dificuldade = 1'b1;
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
      tick();
      n_total++; if (dif_out !== 1'b1) begin n_bad++; $display("FAIL frz_latch got=%0b exp=1", dif_out); end
      wait_state(3'd5, 50, n);
      tick();
      gbus.game_pontuacao = 9'o111;
      gbus.game_pontuacao[2:0] = 3'd5;
      gbus.game_pronto = 3'b001;
      tick();
      gbus.game_pronto = 3'b000;
      wait_state(3'd5, 50, n);
      tick();
      dificuldade = 1'b0;
      minigame = 2'd2;
      modo_torneio = 1'b0;
      repeat (3) tick();
      n_total++; if (dif_out !== 1'b1 || game_sel !== 2'd1) begin n_bad++; $display("FAIL frz_hold got=%0b/%0d exp=1/1", dif_out, game_sel); end
      n_total++; if (db !== 3'd2 || tot !== 5'd5) begin n_bad++; $display("FAIL frz_exec got=%0d/%0d exp=2/5", db, tot); end
      reset = 1'b1;
      gbus.game_pontuacao[5:3] = 3'd7;
      gbus.game_pronto = 3'b010;
      tick();
      n_total++; if (db !== 3'd0 || game_sel !== 2'b11) begin n_bad++; $display("FAIL frz_rst_state got=%0d/%0d exp=0/3", db, game_sel); end
      n_total++; if ({dif_out, gbus.jogar, tot, rodada, timeout, pronto} !== 13'd0) begin n_bad++; $display("FAIL frz_rst_outs got=%h exp=0", {dif_out, gbus.jogar, tot, rodada, timeout, pronto}); end
      n_total++; if (tot_b !== 4'd0) begin n_bad++; $display("FAIL frz_rst_b got=%0d exp=0", tot_b); end
      reset = 1'b0;
      gbus.game_pronto = 3'b000;
      tick();
      n_total++; if (db !== 3'd0) begin n_bad++; $display("FAIL frz_idle got=%0d exp=0", db); end
   endtask

   initial begin
      gbus.game_estado = 12'hCBA;
      gbus.game_pontuacao = 9'o111;
      gbus.game_pronto = 3'b000;
      test_reset();
      test_single();
      test_invalid();
      test_tournament();
      test_saturation();
      test_timeout();
      test_late_done();
      test_freeze_reset();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=running exp=finished");
      $fatal(1);
   end
endmodule

// File: doc/minigame_sequencer.md
Name: minigame_sequencer

Overview:
Parametrised top-level game sequencer for BitBakery. It generalises the fixed 3-minigame select/interval/start/execute/end flow to N_GAMES minigames. It adds a tournament mode that plays every game in order, a per-game execution timeout, and saturating score accumulation across rounds. It sits between the player inputs (already polarity-corrected) and the minigame instances, and drives their start pulses and the debug/serial status fields.

Parameters:
N_GAMES, 3, number of attached minigames (2..2^SEL_W-1)
SEL_W, 2, width of game select; all-ones code means "no game"
STATE_W, 4, width of each game's estado field
SCORE_W, 3, width of each game's pontuacao field
TOTAL_W, 5, width of accumulated score
INTERVAL_CYCLES, 2000, cycles spent in INTERVALO before each game start
TIMEOUT_CYCLES, 0, max cycles in EXECUCAO; 0 disables timeout

Ports:
clock  in  1  system (divided) clock
reset  in  1  synchronous, active-high reset
iniciar  in  1  start/restart request, active-high level
dificuldade  in  1  difficulty select
minigame  in  SEL_W  requested game index
modo_torneio  in  1  1 = play games 0..N_GAMES-1 in sequence
game_estado  in  N_GAMES*STATE_W  packed game states, game k at [k*STATE_W +: STATE_W]
game_pronto  in  N_GAMES  per-game done flags
game_pontuacao  in  N_GAMES*SCORE_W  packed game scores
jogar  out  N_GAMES  one-hot start pulse to the selected game
game_sel  out  SEL_W  latched active game index
dificuldade_out  out  1  latched difficulty
estado_out  out  STATE_W  display state
pontuacao_total  out  TOTAL_W  accumulated score
rodada  out  SEL_W  games completed in the current session
timeout  out  1  sticky: last game ended by timeout
pronto  out  1  high while in FIM
db_estado_seq  out  3  sequencer state code

Behaviour:
- State codes: INICIAL=0, PREPARACAO=1, EXECUCAO=2, FIM=3, INTERVALO=4, START=5. Other codes go to INICIAL on the next edge.
- Reset values (next edge while reset=1, any state): state INICIAL, game_sel all-ones, dificuldade_out 0, jogar 0, pontuacao_total 0, rodada 0, timeout 0, pronto 0, both counters 0. Reset mid-operation aborts immediately and no score is added.
- INICIAL: iniciar=1 -> PREPARACAO. pontuacao_total, rodada and timeout clear on this transition.
- PREPARACAO: dificuldade_out and game_sel track their inputs every cycle. When modo_torneio=1, game_sel is forced to 0.
  - Valid selection (game_sel < N_GAMES) -> INTERVALO.
  - Invalid selection -> stay in PREPARACAO.
  - dificuldade, minigame and modo_torneio are frozen outside INICIAL/PREPARACAO. The tournament flag is latched internally on PREPARACAO exit.
- INTERVALO: interval counter cleared on entry and incremented each cycle. Exactly INTERVAL_CYCLES cycles are spent here, then -> START.
- START: lasts 1 cycle. jogar[game_sel]=1 only in this state, decoded from the state register, so it is a 1-cycle pulse. Then -> EXECUCAO.
- EXECUCAO: timeout counter cleared on entry.
  - game_pronto[game_sel]=1: add game_pontuacao[game_sel] to pontuacao_total, saturating at 2^TOTAL_W-1. Increment rodada. Then:
    - tournament latched and game_sel < N_GAMES-1: game_sel+1, -> INTERVALO.
    - otherwise -> FIM.
  - TIMEOUT_CYCLES>0 and counter reaches TIMEOUT_CYCLES-1 without done: timeout=1, no score added, -> FIM. This also aborts a tournament.
  - Done and timeout in the same cycle: done wins.
  - Done flags of non-selected games are ignored.
- FIM: pronto=1. iniciar=1 -> PREPARACAO, which clears score, rodada and timeout.
- iniciar is ignored in INTERVALO, START and EXECUCAO.
- estado_out:
  - INTERVALO: 4'b0001.
  - START, EXECUCAO, FIM: game_estado slice of game_sel.
  - otherwise: zero-extended state code.
- db_estado_seq = state register.

Decomposition:
- Package bitbakery_pkg: state code constants, the "no game" select constant, and a helper for the saturating-add width.
- One sub-module, seq_timer: clear/enable counter with a parametrised terminal count and terminal flag. Instantiated twice, once for the interval and once for the timeout.
- Slice muxing stays inline.

Test Plan (bench overrides: INTERVAL_CYCLES=8, TIMEOUT_CYCLES=20):
- Single game: minigame=1, iniciar pulse.
  - Required: PREPARACAO, then 8 cycles INTERVALO, then jogar=3'b010 for exactly 1 cycle.
  - Then raise game_pronto[1] with score 5 -> FIM, pontuacao_total=5, rodada=1, pronto=1.
- Invalid select: minigame=3 (N_GAMES=3) -> holds PREPARACAO indefinitely. Change minigame to 0 -> INTERVALO on the next edge.
- Tournament: modo_torneio=1, scores 3, 4, 7.
  - Required: jogar 001, then 010, then 100, each preceded by 8 INTERVALO cycles.
  - Then FIM with total=14, rodada=3.
- Saturation (TOTAL_W=4): tournament scores 7, 7, 7 -> total 7, then 14, then 15 (saturated).
- Timeout cases:
  - No pronto for 20 EXECUCAO cycles -> FIM, timeout=1, total unchanged; a tournament stops at the current game.
  - Pronto asserted on cycle 20 -> scored, timeout=0.
- Freeze and reset:
  - Toggle dificuldade during EXECUCAO -> dificuldade_out unchanged.
  - Assert reset in EXECUCAO -> next edge INICIAL with all outputs at reset values.
